// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame parser: FSM state encoding,
// error codes reported on err_code, and the default start-of-frame byte.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CSUM    = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_PARITY = 2'd1;
  localparam logic [1:0] ERR_CSUM   = 2'd2;
  localparam logic [1:0] ERR_LEN    = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/frame_idle_timer.sv
// Counts idle cycles while running; expired pulses on the cycle whose count
// would reach TIMEOUT. A clear takes priority over counting.
module frame_idle_timer #(
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (run)       cnt <= cnt + 1'b1;
  end

  assign expired = run && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Pops bytes from a UART RX FIFO and parses SOF/LEN/payload/XOR-checksum frames.
// Define UART_FRAME_TIMEOUT_EN to abort frames that stall for TIMEOUT idle cycles.
module uart_rx_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int              DBIT    = 8,
  parameter int              MAX_LEN = 16,
  parameter logic [DBIT-1:0] SOF     = DBIT'(SOF_DEFAULT),
  parameter int              TIMEOUT = 50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  input  logic            par_err,
  output logic            rd_uart,
  output logic [DBIT-1:0] pl_data,
  output logic            pl_valid,
  output logic            frame_done,
  output logic            frame_err,
  output logic [1:0]      err_code,
  output logic [15:0]     ok_cnt
);

  state_t          state, state_n;
  logic [DBIT-1:0] cnt, cnt_n;
  logic [DBIT-1:0] csum, csum_n;
  logic            perr, perr_n;
  logic [DBIT-1:0] pl_data_n;
  logic            pl_valid_n, done_n, err_n;
  logic [1:0]      code_n;
  logic [15:0]     ok_n;
  logic            take, len_bad, tmo;

  assign rd_uart = ~rx_empty & ~reset;
  assign take    = rd_uart;
  assign len_bad = (r_data == '0) || (r_data > DBIT'(MAX_LEN));

`ifdef UART_FRAME_TIMEOUT_EN
  frame_idle_timer #(.TIMEOUT(TIMEOUT)) u_idle (
    .clk    (clk),
    .reset  (reset),
    .clear  (take || (state == HUNT) || tmo),
    .run    (rx_empty && (state != HUNT)),
    .expired(tmo)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= HUNT;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (tmo) state_n = HUNT;
    else if (take) begin
      case (state)
        HUNT:    if (r_data == SOF && !par_err) state_n = LEN;
        LEN:     state_n = (par_err || len_bad) ? HUNT : PAYLOAD;
        PAYLOAD: if (cnt == DBIT'(1)) state_n = CSUM;
        CSUM:    state_n = HUNT;
        default: state_n = HUNT;
      endcase
    end
  end

  // Next values of the datapath and registered outputs; strobes default low.
  always_comb begin
    cnt_n      = cnt;
    csum_n     = csum;
    perr_n     = perr;
    pl_data_n  = pl_data;
    pl_valid_n = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;
    code_n     = err_code;
    ok_n       = ok_cnt;
    if (tmo) begin
      err_n  = 1'b1;
      code_n = ERR_LEN;
    end else if (take) begin
      case (state)
        LEN: begin
          if (par_err) begin
            err_n  = 1'b1;
            code_n = ERR_PARITY;
          end else if (len_bad) begin
            err_n  = 1'b1;
            code_n = ERR_LEN;
          end else begin
            cnt_n  = r_data;
            csum_n = r_data;
            perr_n = 1'b0;
          end
        end
        PAYLOAD: begin
          pl_data_n  = r_data;
          pl_valid_n = 1'b1;
          csum_n     = csum ^ r_data;
          perr_n     = perr | par_err;
          cnt_n      = cnt - 1'b1;
        end
        CSUM: begin
          if (perr || par_err) begin
            err_n  = 1'b1;
            code_n = ERR_PARITY;
          end else if (r_data != csum) begin
            err_n  = 1'b1;
            code_n = ERR_CSUM;
          end else begin
            done_n = 1'b1;
            code_n = ERR_NONE;
            ok_n   = ok_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      csum       <= '0;
      perr       <= 1'b0;
      pl_data    <= '0;
      pl_valid   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_NONE;
      ok_cnt     <= '0;
    end else begin
      cnt        <= cnt_n;
      csum       <= csum_n;
      perr       <= perr_n;
      pl_data    <= pl_data_n;
      pl_valid   <= pl_valid_n;
      frame_done <= done_n;
      frame_err  <= err_n;
      err_code   <= code_n;
      ok_cnt     <= ok_n;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Scoreboard bench: frame-level reference model pushes expected strobes,
// a negedge monitor pops and compares whatever the parser emits.
module tb_uart_rx_frame_parser;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 50000;
`endif
  localparam int MAXL = 16;

  logic        clk = 1'b0;
  logic        reset, rx_empty, par_err;
  logic [7:0]  r_data;
  logic        rd_uart, pl_valid, frame_done, frame_err;
  logic [7:0]  pl_data;
  logic [1:0]  err_code;
  logic [15:0] ok_cnt;

  uart_rx_frame_parser #(.DBIT(8), .MAX_LEN(MAXL), .SOF(8'hA5), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .par_err(par_err),
    .rd_uart(rd_uart), .pl_data(pl_data), .pl_valid(pl_valid), .frame_done(frame_done),
    .frame_err(frame_err), .err_code(err_code), .ok_cnt(ok_cnt)
  );

  always #5 clk = ~clk;

  // kind: 0 payload byte (val=data), 1 frame_done, 2 frame_err (val=code)
  typedef struct { int kind; int val; int ok; } ev_t;
  ev_t q[$];
  int  total = 0, bad = 0, model_ok = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ev_t mk(input int kind, input int val, input int ok);
    ev_t e;
    e.kind = kind; e.val = val; e.ok = ok;
    return e;
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (!reset && (pl_valid || frame_done || frame_err)) begin
      chk("done_err_excl", int'(frame_done & frame_err), 0);
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_strobe actual=v%0b d%0b e%0b expected=none", pl_valid, frame_done, frame_err);
      end else begin
        e = q.pop_front();
        chk("kind", pl_valid ? 0 : (frame_done ? 1 : 2), e.kind);
        if (e.kind == 0) chk("pl_data", int'(pl_data), e.val);
        else begin
          chk("err_code", int'(err_code), e.val);
          chk("ok_cnt", int'(ok_cnt), e.ok);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic pe, input int gap);
    rx_empty = 1'b0; r_data = b; par_err = pe;
    @(negedge clk);
    rx_empty = 1'b1; par_err = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Frame-level model: pidx marks the byte with a parity error
  // (0 = LEN, 1..len = payload, len+1 = checksum, -1 = none).
  task automatic send_frame(input int len, input bit badc, input int pidx, input int gmax);
    logic [7:0] pl[$];
    logic [7:0] cs;
    pl.delete();
    cs = len[7:0];
    if (pidx == 0) q.push_back(mk(2, 1, model_ok));
    else if (len == 0 || len > MAXL) q.push_back(mk(2, 3, model_ok));
    else begin
      for (int i = 0; i < len; i++) begin
        pl.push_back(8'($urandom_range(0, 255)));
        cs = cs ^ pl[i];
        q.push_back(mk(0, int'(pl[i]), 0));
      end
      if (pidx >= 1 && pidx <= len + 1) q.push_back(mk(2, 1, model_ok));
      else if (badc) q.push_back(mk(2, 2, model_ok));
      else begin model_ok = (model_ok + 1) & 16'hFFFF; q.push_back(mk(1, 0, model_ok)); end
      if (badc) cs = cs ^ 8'($urandom_range(1, 255));
    end
    send_byte(8'hA5, 1'b0, $urandom_range(0, gmax));
    send_byte(len[7:0], pidx == 0, $urandom_range(0, gmax));
    if (pidx != 0 && len != 0 && len <= MAXL) begin
      for (int i = 0; i < len; i++) send_byte(pl[i], pidx == i + 1, $urandom_range(0, gmax));
      send_byte(cs, pidx == len + 1, $urandom_range(0, gmax));
    end
  endtask

  task automatic send_list(input logic [7:0] b[$]);
    foreach (b[i]) send_byte(b[i], 1'b0, 0);
  endtask

  initial begin
    reset = 1'b1; rx_empty = 1'b0; r_data = 8'hA5; par_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rd_uart", int'(rd_uart), 0);
    chk("rst_pl_valid", int'(pl_valid), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_err", int'(frame_err), 0);
    chk("rst_code", int'(err_code), 0);
    chk("rst_ok", int'(ok_cnt), 0);
    chk("rst_pl_data", int'(pl_data), 0);
    rx_empty = 1'b1; reset = 1'b0;
    @(negedge clk);
    chk("rd_uart_empty", int'(rd_uart), 0);

    // good frame
    q.push_back(mk(0, 'h11, 0)); q.push_back(mk(0, 'h22, 0)); q.push_back(mk(0, 'h33, 0));
    q.push_back(mk(1, 0, 1)); model_ok = 1;
    send_list('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
    // bad checksum
    q.push_back(mk(0, 'h11, 0)); q.push_back(mk(0, 'h22, 0)); q.push_back(mk(0, 'h33, 0));
    q.push_back(mk(2, 2, 1));
    send_list('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04});
    // garbage then frame
    q.push_back(mk(0, 'h7E, 0)); q.push_back(mk(1, 0, 2)); model_ok = 2;
    send_list('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h7E, 8'h7F});
    // length errors
    q.push_back(mk(2, 3, 2)); send_list('{8'hA5, 8'h00});
    q.push_back(mk(2, 3, 2)); send_list('{8'hA5, 8'h11});
    // parity error on second payload byte
    q.push_back(mk(0, 'h10, 0)); q.push_back(mk(0, 'h20, 0)); q.push_back(mk(2, 1, 2));
    send_byte(8'hA5, 1'b0, 0); send_byte(8'h02, 1'b0, 0);
    send_byte(8'h10, 1'b0, 0); send_byte(8'h20, 1'b1, 0); send_byte(8'h30, 1'b0, 0);

    // reset mid-frame: only the already-taken payload byte appears
    q.push_back(mk(0, 'h10, 0));
    send_list('{8'hA5, 8'h02, 8'h10});
    repeat (2) @(negedge clk);
    reset = 1'b1; rx_empty = 1'b0; r_data = 8'h55;
    repeat (2) @(negedge clk);
    reset = 1'b0; rx_empty = 1'b1; model_ok = 0;
    @(negedge clk);
    chk("mid_rst_ok", int'(ok_cnt), 0);
    chk("mid_rst_code", int'(err_code), 0);
    chk("mid_rst_q", q.size(), 0);
    q.push_back(mk(0, 'h10, 0)); q.push_back(mk(0, 'h20, 0)); q.push_back(mk(1, 0, 1)); model_ok = 1;
    send_list('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32});

    // randomized frames with hunt-phase garbage
    for (int f = 0; f < 60; f++) begin
      int ng = $urandom_range(0, 3);
      for (int g = 0; g < ng; g++) begin
        logic [7:0] gb;
        gb = 8'($urandom_range(0, 255));
        if (gb == 8'hA5) send_byte(gb, 1'b1, $urandom_range(0, 2));
        else send_byte(gb, $urandom_range(0, 1) == 1, $urandom_range(0, 2));
      end
      send_frame($urandom_range(0, 9) == 0 ? $urandom_range(17, 255) : $urandom_range(0, MAXL),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0 ? $urandom_range(0, MAXL + 1) : -1,
                 2);
    end

`ifdef UART_FRAME_TIMEOUT_EN
    begin
      int k;
      repeat (5) @(negedge clk);
      q.push_back(mk(0, 'h10, 0)); q.push_back(mk(2, 3, model_ok));
      send_list('{8'hA5, 8'h02, 8'h10});
      k = 0;
      while (!frame_err && k < 300) begin @(negedge clk); k++; end
      chk("timeout_cycles", k, 100);
    end
`endif

    begin
      int w = 0;
      while (q.size() != 0 && w < 100) begin @(negedge clk); w++; end
      chk("scoreboard_drained", q.size(), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
